// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: two-flop synchroniser, stability-count debounce filter,
// and press / release / auto-repeat strobe generation for the downstream counter.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk100_i,
    input  logic rst_i,
    input  logic bt_i,
    output logic level_o,
    output logic btnd_o,
    output logic press_o,
    output logic rel_o
);

    localparam int CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic          s1;
    logic          s2;
    logic [CW-1:0] stab_cnt;
    logic [HW-1:0] hold_cnt;
    logic [1:0]    state;
    logic          accept;
    logic          rise;
    logic          fall;

    // A level change is accepted on the edge where the stability count would hit its target.
    assign accept = (s2 != level_o) && (stab_cnt == DB_LAST);
    assign rise   = accept && s2;
    assign fall   = accept && !s2;

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bt_i;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            level_o  <= 1'b0;
            stab_cnt <= '0;
        end else if (s2 != level_o) begin
            if (stab_cnt == DB_LAST) begin
                level_o  <= s2;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end else begin
            stab_cnt <= '0;
        end
    end

    // Release is checked before any repeat so a coincident fall suppresses the repeat strobe.
    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            btnd_o   <= 1'b0;
            press_o  <= 1'b0;
            rel_o    <= 1'b0;
        end else begin
            btnd_o  <= 1'b0;
            press_o <= 1'b0;
            rel_o   <= 1'b0;
            if (rise) begin
                state    <= ST_HELD;
                press_o  <= 1'b1;
                btnd_o   <= 1'b1;
                hold_cnt <= '0;
            end else if (fall) begin
                state    <= ST_IDLE;
                rel_o    <= 1'b1;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ST_HELD: begin
                        if ((REPEAT_EN != 0) && (hold_cnt == DELAY_LAST)) begin
                            btnd_o   <= 1'b1;
                            state    <= ST_REPEAT;
                            hold_cnt <= '0;
                        end else if (hold_cnt != '1) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (hold_cnt == PERIOD_LAST) begin
                            btnd_o   <= 1'b1;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: one instance without repeat (DEBOUNCE_CYCLES=4)
// and one with auto-repeat (DEBOUNCE_CYCLES=2, delay 10, period 3).
module tb_btn_conditioner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, bt_a, lvl_a, btnd_a, press_a, rel_a;
    logic rst_b, bt_b, lvl_b, btnd_b, press_b, rel_b;

    int checks = 0;
    int passes = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN(0),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut_a (
        .clk100_i(clk),
        .rst_i(rst_a),
        .bt_i(bt_a),
        .level_o(lvl_a),
        .btnd_o(btnd_a),
        .press_o(press_a),
        .rel_o(rel_a)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES(2),
        .REPEAT_EN(1),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut_b (
        .clk100_i(clk),
        .rst_i(rst_b),
        .bt_i(bt_b),
        .level_o(lvl_b),
        .btnd_o(btnd_b),
        .press_o(press_b),
        .rel_o(rel_b)
    );

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got %0b expected %0b", tag, obs, exp);
    endtask

    task automatic checkA(input string tag, input logic l, input logic p, input logic b, input logic r);
        checkOutput({tag, " level"}, lvl_a, l);
        checkOutput({tag, " press"}, press_a, p);
        checkOutput({tag, " btnd"}, btnd_a, b);
        checkOutput({tag, " rel"}, rel_a, r);
    endtask

    task automatic checkB(input string tag, input logic l, input logic p, input logic b, input logic r);
        checkOutput({tag, " level"}, lvl_b, l);
        checkOutput({tag, " press"}, press_b, p);
        checkOutput({tag, " btnd"}, btnd_b, b);
        checkOutput({tag, " rel"}, rel_b, r);
    endtask

    // Inputs change on the falling edge, so the next rising edge is edge 0 of a sequence.
    task automatic applyStimulus(input int sel, input logic value);
        if (sel == 0)
            bt_a = value;
        else
            bt_b = value;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bt_a  = 1'b0;
        bt_b  = 1'b0;
        repeat (3) @(negedge clk);
        checkA("reset A", 1'b0, 1'b0, 1'b0, 1'b0);
        checkB("reset B", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] clean press, held with repeat disabled");
        applyStimulus(0, 1'b1);
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            checkA($sformatf("press e%0d", i), i >= 5, i == 5, i == 5, 1'b0);
        end

        $display("[TB] clean release");
        applyStimulus(0, 1'b0);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            checkA($sformatf("release e%0d", i), i < 5, 1'b0, 1'b0, i == 5);
        end

        $display("[TB] bouncing input then steady press");
        for (int s = 0; s < 4; s++) begin
            applyStimulus(0, (s % 2) == 0);
            repeat (2) begin
                @(negedge clk);
                checkA($sformatf("bounce s%0d", s), 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        applyStimulus(0, 1'b1);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            checkA($sformatf("settle e%0d", i), i >= 5, i == 5, i == 5, 1'b0);
        end

        $display("[TB] reset while held");
        rst_a = 1'b1;
        @(negedge clk);
        checkA("midrst c0", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkA("midrst c1", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            checkA($sformatf("postrst e%0d", i), i >= 5, i == 5, i == 5, 1'b0);
        end

        $display("[TB] auto-repeat, release coincident with repeat");
        applyStimulus(1, 1'b1);
        for (int i = 0; i <= 45; i++) begin
            @(negedge clk);
            checkB($sformatf("rpt e%0d", i),
                   (i >= 3) && (i < 43),
                   i == 3,
                   ((i == 3) || ((i >= 13) && (((i - 13) % 3) == 0))) && (i < 43),
                   i == 43);
            if (i == 39)
                applyStimulus(1, 1'b0);
        end

        $display("[TB] second press after return to idle");
        applyStimulus(1, 1'b1);
        for (int i = 0; i <= 14; i++) begin
            @(negedge clk);
            checkB($sformatf("repress e%0d", i), i >= 3, i == 3, (i == 3) || (i == 13), 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream stage for the counter/register capture logic.
- Takes one raw, asynchronous, bouncing pushbutton level (already inverted to active-high by the instantiating module) and produces a clean debounced level plus single-cycle event pulses.
- Synchronises the input, filters bounce with a stability counter, and emits press, release and optional auto-repeat pulses.
- btnd_o is the one-cycle strobe the downstream counter consumes; each pulse advances the count by exactly one.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a level change (10 ms at 100 MHz); legal range >=1.
- REPEAT_EN, 0, 1 enables auto-repeat pulses on btnd_o while the button is held.
- REPEAT_DELAY, 50000000, cycles from accepted press to first repeat pulse (0.5 s); legal range >=1.
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (0.1 s); legal range >=1.

Ports:
- clk100_i  in  1  system clock, 100 MHz.
- rst_i  in  1  asynchronous reset, active-high.
- bt_i  in  1  raw button level, active-high (1 = pressed), asynchronous to clk100_i.
- level_o  out  1  debounced button level.
- btnd_o  out  1  one-cycle strobe on accepted press and on each repeat.
- press_o  out  1  one-cycle strobe on accepted press only.
- rel_o  out  1  one-cycle strobe on accepted release.

Behaviour:
- Reset (rst_i=1, async assert, sync deassert by the environment):
  - Both synchroniser flops, level_o, btnd_o, press_o, rel_o, the stability counter and the hold counter clear to 0.
  - State machine goes to IDLE.
- Synchroniser: two flops, bt_i -> s1 -> s2. s2 is the only signal the filter uses. bt_i is never used combinationally.
- Stability counter:
  - Each edge where s2 != level_o increments the counter.
  - Each edge where s2 == level_o clears it.
  - At the edge where the counter would reach DEBOUNCE_CYCLES, level_o toggles and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES+1). It never wraps.
- Latency: let k be the first edge that samples a new bt_i value, held steady. level_o changes at edge k+1+DEBOUNCE_CYCLES.
- Bounce handling: any single-cycle return of s2 to level_o before the count completes restarts the count from 0.
- State machine: IDLE, HELD, REPEAT.
  - IDLE -> HELD on accepted rise of level_o. press_o=1 and btnd_o=1 for exactly that one cycle, registered and coincident with level_o rising. Hold counter cleared.
  - HELD:
    - The hold counter increments every cycle.
    - If REPEAT_EN=1 and the hold counter reaches REPEAT_DELAY, btnd_o=1 for one cycle, go to REPEAT, and the hold counter clears.
    - If REPEAT_EN=0, the machine stays in HELD and the hold counter saturates.
  - REPEAT: the hold counter increments. On reaching REPEAT_PERIOD, btnd_o=1 for one cycle and the hold counter clears.
  - HELD or REPEAT -> IDLE on accepted fall of level_o. rel_o=1 for that one cycle, btnd_o=0, hold counter cleared.
- Priority: if an accepted fall coincides with a repeat pulse due, the release wins. rel_o=1 and btnd_o=0 on that cycle.
- Pulse rules:
  - btnd_o, press_o and rel_o are registered outputs.
  - Each is high for at most one consecutive cycle.
  - press_o and rel_o are never high together.
- Hold counter width: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- Reset mid-operation: all outputs drop to 0 immediately.
  - If bt_i is still high after reset release, a fresh press is accepted at edge k+1+DEBOUNCE_CYCLES, with k the first edge after deassert.
  - No rel_o is produced for the press interrupted by reset.
- Button held forever with REPEAT_EN=0: exactly one btnd_o pulse is produced, and none after.

Test Plan:
- DEBOUNCE_CYCLES=4, REPEAT_EN=0; bt_i rises before edge 0 and stays high -> level_o, press_o and btnd_o go high after edge 5. press_o and btnd_o drop after edge 6. level_o stays 1.
- DEBOUNCE_CYCLES=4; bt_i toggles 1,0,1,0 every 2 cycles, then holds 1 -> no pulse during bouncing. Exactly one btnd_o occurs 5 edges after the final rise is first sampled.
- DEBOUNCE_CYCLES=4; after an accepted press, bt_i falls -> rel_o=1 for one cycle at edge k+5, level_o=0, btnd_o stays 0.
- DEBOUNCE_CYCLES=2, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3; hold for 30 cycles -> btnd_o pulses at press cycle P, P+10, P+13, P+16, ... Only the first pulse has press_o=1.
- Press accepted, then rst_i pulsed high for 2 cycles mid-hold with bt_i still high -> outputs are 0 during reset with no rel_o. A new press_o/btnd_o pulse occurs DEBOUNCE_CYCLES+1 edges after the first post-reset edge.
- REPEAT_EN=1; the release is accepted on the exact cycle a repeat is due -> rel_o=1, btnd_o=0 that cycle, state returns to IDLE.
